// File: rtl/mem_loader_pkg.sv
// Shared types and sizing for the byte-memory fill loader.
package mem_loader_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int mem_depth(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/mem_loader_ram.sv
// DEPTH x DATA_W byte store: one synchronous write port, one registered
// read port that returns the pre-write contents on an address collision.
module mem_loader_ram
  import mem_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = mem_depth(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read register samples the array before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;
endmodule

// File: rtl/mem_fill_loader.sv
// Fill stage: writes a counted valid/ready byte stream into a wrapping
// byte memory from a captured base address, with a registered read port.
module mem_fill_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W:0]   r_wr_count;
  logic              w_xfer;

  // An abort wins over a simultaneous beat, so nothing is written that cycle.
  assign w_xfer   = (r_state == LOAD) && in_valid && !abort;
  assign in_ready = (r_state == LOAD);
  assign busy     = (r_state == LOAD);
  assign done     = (r_state == DONE);
  assign wr_count = r_wr_count;

  // Fill sequencer: pointer, remaining count and written count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_wr_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ptr       <= base_addr;
            r_remaining <= length;
            r_wr_count  <= '0;
            r_state     <= (length != '0) ? LOAD : DONE;
          end
        end
        LOAD: begin
          if (abort) begin
            r_state <= IDLE;
          end else if (in_valid) begin
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - (ADDR_W + 1)'(1);
            r_wr_count  <= r_wr_count + (ADDR_W + 1)'(1);
            if (r_remaining == (ADDR_W + 1)'(1)) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  mem_loader_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (w_xfer),
    .waddr(r_ptr),
    .wdata(in_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_mem_fill_loader.sv
// Scoreboard bench for mem_fill_loader: stimulus pushes expectations derived
// from an array model of memory; a negedge monitor pops and compares.
module tb_mem_fill_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic [8:0] length = 9'd0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] rd_addr = 8'h00;
  logic       in_ready, busy, done;
  logic [7:0] rd_data;
  logic [8:0] wr_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_mem [256];
  logic [7:0] rd_q [$];
  int         done_q [$];
  logic [7:0] fixed_q [$];

  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  bit   m_wr_chk = 1'b1;
  int   m_wr_count = 0;
  bit   rd_en = 1'b0;
  bit   rd_pushed = 1'b0;
  bit   rd_live = 1'b0;
  bit   force_rd = 1'b0;
  logic [7:0] force_addr = 8'h00;

  mem_fill_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A read issued in one cycle is due on the following cycle.
  always @(posedge clk) rd_live <= rd_pushed;

  // Monitor: control outputs against the abstract model, data against queues.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("in_ready", 32'(in_ready), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    if (m_wr_chk) chk("wr_count", 32'(wr_count), 32'(m_wr_count));
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        int e;
        e = done_q.pop_front();
        if (e >= 0) chk("done_wr_count", 32'(wr_count), 32'(e));
      end
    end
    if (rd_live) begin
      if (rd_q.size() == 0) chk("rd_q_underflow", 32'd1, 32'd0);
      else chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
    end
  end

  // One clock: apply the write that edge performed, then issue the next read.
  task automatic step(input bit wr, input logic [7:0] wa, input logic [7:0] wd);
    @(posedge clk);
    #1;
    if (wr) model_mem[wa] = wd;
    if (rd_en) begin
      rd_addr = force_rd ? force_addr : 8'($urandom);
      rd_q.push_back(model_mem[rd_addr]);
      rd_pushed = 1'b1;
    end else begin
      rd_pushed = 1'b0;
    end
  endtask

  // mode: 0 = in_valid always high, 1 = toggling 1,0,1,0, 2 = random with start noise.
  task automatic fill(input logic [7:0] b, input logic [8:0] l, input int mode, input int abort_at);
    int n = 0;
    int cyc = 0;
    logic [7:0] p = b;
    bit v;
    bit tog = 1'b1;
    logic [7:0] d;
    start = 1'b1;
    base_addr = b;
    length = l;
    step(1'b0, 8'h00, 8'h00);
    start = 1'b0;
    base_addr = 8'($urandom);
    length = 9'($urandom);
    if (l == 9'd0) begin
      m_done = 1'b1;
      m_wr_chk = 1'b0;
      done_q.push_back(-1);
      step(1'b0, 8'h00, 8'h00);
      m_done = 1'b0;
      return;
    end
    m_busy = 1'b1;
    m_wr_chk = 1'b1;
    m_wr_count = 0;
    while (1) begin
      cyc++;
      if (cyc > 4000) begin
        chk("fill_timeout", 32'(cyc), 32'd0);
        break;
      end
      if (n == abort_at) begin
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = 8'($urandom);
        step(1'b0, 8'h00, 8'h00);
        abort = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        m_busy = 1'b0;
        break;
      end
      case (mode)
        0: v = 1'b1;
        1: begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      d = (v && fixed_q.size() != 0) ? fixed_q.pop_front() : 8'($urandom);
      in_valid = v;
      in_data = d;
      if (mode == 2) start = 1'($urandom);
      step(v, p, d);
      if (v) begin
        p++;
        n++;
        m_wr_count = n;
      end
      if (n == int'(l)) begin
        in_valid = (mode == 2) ? 1'($urandom) : 1'b0;
        m_busy = 1'b0;
        m_done = 1'b1;
        done_q.push_back(int'(l));
        step(1'b0, 8'h00, 8'h00);
        m_done = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        break;
      end
    end
  endtask

  task automatic read_sweep(input logic [7:0] a, input int cnt);
    force_rd = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      force_addr = a + 8'(i);
      step(1'b0, 8'h00, 8'h00);
    end
    force_rd = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p;
    logic [7:0] d;
    #1;
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_wr_count", 32'(wr_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-depth fill defines every location and wraps back to base.
    fill(8'($urandom), 9'd256, 0, -1);
    rd_en = 1'b1;

    fixed_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    fill(8'h10, 9'd4, 0, -1);
    fixed_q = '{8'h11, 8'h22, 8'h33};
    fill(8'hFE, 9'd3, 0, -1);
    fill(8'($urandom), 9'd0, 0, -1);
    fill(8'h80, 9'd2, 1, -1);
    fill(8'h60, 9'd5, 0, 2);

    fixed_q = '{8'hC3};
    fill(8'h20, 9'd1, 0, -1);
    force_rd = 1'b1;
    force_addr = 8'h20;
    fixed_q = '{8'h5A};
    fill(8'h20, 9'd1, 0, -1);
    step(1'b0, 8'h00, 8'h00);
    force_rd = 1'b0;

    read_sweep(8'h10, 4);
    read_sweep(8'hFE, 3);
    read_sweep(8'h60, 6);
    read_sweep(8'h80, 2);

    for (int k = 0; k < 20; k++) begin
      int l;
      int ab;
      l = ($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(0, 40));
      ab = (l != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, l - 1)) : -1;
      fill(8'($urandom), 9'(l), 2, ab);
      repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, 8'h00);
    end

    // Reset in the middle of a fill: outputs clear at once, bytes survive.
    rd_en = 1'b0;
    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    start = 1'b1;
    base_addr = 8'h40;
    length = 9'd10;
    step(1'b0, 8'h00, 8'h00);
    start = 1'b0;
    m_busy = 1'b1;
    m_wr_count = 0;
    m_wr_chk = 1'b1;
    p = 8'h40;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      in_valid = 1'b1;
      in_data = d;
      step(1'b1, p, d);
      p++;
      m_wr_count = i + 1;
    end
    #2;
    rst_n = 1'b0;
    m_busy = 1'b0;
    m_wr_count = 0;
    in_valid = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_wr_count", 32'(wr_count), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    rd_en = 1'b1;
    read_sweep(8'h40, 5);

    rd_en = 1'b0;
    repeat (3) step(1'b0, 8'h00, 8'h00);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
